// File: rtl/bt_cmd_rx_pkg.sv
// bt_cmd_rx_pkg: direction codes, command bytes, UART receiver states and command decoder
// Imported by uart_rx_core and bt_cmd_rx; no ports.
package bt_cmd_rx_pkg;
  localparam logic [3:0] DIR_UP = 4'b1000, DIR_DOWN = 4'b0100, DIR_LEFT = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001, DIR_STOP = 4'b0000;
  // Upper-case forms; bit5 is masked off before comparison, so lower case matches too.
  localparam logic [7:0] CMD_W = 8'h57, CMD_S = 8'h53, CMD_A = 8'h41, CMD_D = 8'h44;
  localparam logic [7:0] CMD_X = 8'h58, CMD_SPACE = 8'h20;
  localparam logic [7:0] CASE_MASK = 8'hdf;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;
  typedef struct packed {
    logic       hit;
    logic [3:0] dir;
  } cmd_t;
  function automatic cmd_t decode_cmd(input logic [7:0] b);
    logic [7:0] u;
    u = b & CASE_MASK;
    return u == CMD_W ? cmd_t'{1'b1, DIR_UP} :
           u == CMD_S ? cmd_t'{1'b1, DIR_DOWN} :
           u == CMD_A ? cmd_t'{1'b1, DIR_LEFT} :
           u == CMD_D ? cmd_t'{1'b1, DIR_RIGHT} :
           (u == CMD_X || u == (CMD_SPACE & CASE_MASK)) ? cmd_t'{1'b1, DIR_STOP} :
           cmd_t'{1'b0, DIR_STOP};
  endfunction
endpackage

// File: rtl/bt_cmd_rx_uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with 2-flop input synchroniser
// Ports:
//   clk, rst      system clock, asynchronous active-low reset
//   i_rx          raw UART line (idle high, asynchronous to clk)
//   o_rx_byte     last correctly framed byte
//   o_byte_valid  1-clk pulse when o_rx_byte updates
//   o_frame_err   1-clk pulse when the stop bit is sampled low
//   o_done        combinational strobe on the clk whose edge commits a good byte
//   o_data        shift register contents (the byte being committed when o_done)
module uart_rx_core
  import bt_cmd_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_rx_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_done,
  output logic [7:0] o_data
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  rx_state_e r_state, w_next;
  logic r_sync1, r_sync2;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic w_rxs, w_half, w_tick, w_sample, w_done, w_ferr, w_cnt_clr;
  assign w_rxs  = r_sync2;
  assign w_half = r_cnt == HALF_LAST;
  assign w_tick = r_cnt == BIT_LAST;
  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    w_done   = 1'b0;
    w_ferr   = 1'b0;
    case (r_state)
      ST_IDLE:  if (!w_rxs) w_next = ST_START;
      ST_START: if (w_half) w_next = w_rxs ? ST_IDLE : ST_DATA;
      ST_DATA: if (w_tick) begin
        w_sample = 1'b1;
        w_next   = r_bit == 3'd7 ? ST_STOP : ST_DATA;
      end
      ST_STOP: if (w_tick) begin
        w_done = w_rxs;
        w_ferr = !w_rxs;
        w_next = w_rxs ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: if (w_rxs) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end
  // Baud counter restarts on every state change and on each data sample.
  assign w_cnt_clr = w_next != r_state || w_tick || r_state == ST_IDLE || r_state == ST_BREAK;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      o_rx_byte    <= '0;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      r_sync1      <= i_rx;
      r_sync2      <= r_sync1;
      r_cnt        <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      r_bit        <= r_state == ST_IDLE ? 3'd0 : w_sample ? r_bit + 3'd1 : r_bit;
      r_shift      <= w_sample ? {w_rxs, r_shift[7:1]} : r_shift;
      o_rx_byte    <= w_done ? r_shift : o_rx_byte;
      o_byte_valid <= w_done;
      o_frame_err  <= w_ferr;
    end
  end
  assign o_done = w_done;
  assign o_data = r_shift;
endmodule

// File: rtl/bt_cmd_rx.sv
// bt_cmd_rx: Bluetooth UART command receiver producing a held WASD direction code
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   rx          raw UART line from the BT module (idle high)
//   dir         held direction: 1000 up, 0100 down, 0010 left, 0001 right, 0000 stop
//   rx_byte     last correctly framed byte
//   byte_valid  1-clk pulse when rx_byte updates
//   frame_err   1-clk pulse when a stop bit is sampled low
module bt_cmd_rx
  import bt_cmd_rx_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int BAUD           = 9600,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] dir,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TW = TIMEOUT_CYCLES == 0 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  logic w_done, w_hit, w_expire;
  logic [7:0] w_data;
  cmd_t w_cmd;
  logic [3:0] r_dir;
  logic [TW-1:0] r_to_cnt;
  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (rx),
    .o_rx_byte   (rx_byte),
    .o_byte_valid(byte_valid),
    .o_frame_err (frame_err),
    .o_done      (w_done),
    .o_data      (w_data)
  );
  // Decode the byte being committed so dir changes on the same edge as byte_valid.
  assign w_cmd    = decode_cmd(w_data);
  assign w_hit    = w_done && w_cmd.hit;
  assign w_expire = TIMEOUT_CYCLES != 0 && r_to_cnt == TO_LAST;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dir    <= DIR_STOP;
      r_to_cnt <= '0;
    end else begin
      r_dir    <= w_hit ? w_cmd.dir : w_expire ? DIR_STOP : r_dir;
      r_to_cnt <= (w_hit || TIMEOUT_CYCLES == 0) ? '0 : w_expire ? r_to_cnt : r_to_cnt + 1'b1;
    end
  end
  assign dir = r_dir;
endmodule
